// File: rtl/iq_frame_controller_pkg.sv
// Shared system parameters for the IQ compression datapath.
// Provides the scaling-factor width (reused as the control-word width), the default
// compression frame length, the default requester count and the frame sequencer state type.
package iq_frame_controller_pkg;

  localparam int SCALING_FACTOR_BITWIDTH = 8;
  localparam int FRAME_LEN_DEFAULT       = 16;
  localparam int NUM_CTRL_REQ            = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } frame_state_t;

endpackage

// File: rtl/iq_frame_controller_if.sv
// Handshake/bus bundle for iq_frame_controller.
// master: sample source and control-word requesters (drive enable, inValid, ctrlReq, ctrlWord).
// slave:  the frame controller (drives ctrlAck, frameStart, sampleIdx, controlData,
//         controlValid, frameCount, busy).
interface iq_frame_controller_if #(
  parameter int FRAME_LEN  = 16,
  parameter int NUM_REQ    = 4,
  parameter int CTRL_WIDTH = 8
);

  logic                            enable;
  logic                            inValid;
  logic [NUM_REQ-1:0]              ctrlReq;
  logic [NUM_REQ*CTRL_WIDTH-1:0]   ctrlWord;
  logic [NUM_REQ-1:0]              ctrlAck;
  logic                            frameStart;
  logic [$clog2(FRAME_LEN)-1:0]    sampleIdx;
  logic [CTRL_WIDTH-1:0]           controlData;
  logic                            controlValid;
  logic [15:0]                     frameCount;
  logic                            busy;

  modport master (
    output enable, inValid, ctrlReq, ctrlWord,
    input  ctrlAck, frameStart, sampleIdx, controlData, controlValid, frameCount, busy
  );

  modport slave (
    input  enable, inValid, ctrlReq, ctrlWord,
    output ctrlAck, frameStart, sampleIdx, controlData, controlValid, frameCount, busy
  );

endinterface

// File: rtl/iq_frame_controller_rr_arbiter.sv
// Combinational round-robin arbiter.
// req    : per-requester request bits
// ptr    : requester index with highest priority this evaluation
// grant  : one-hot grant (all zero when no request)
// winner : index of the granted requester (0 when no request)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  always_comb begin
    int         pos;
    logic       found;
    logic [PTR_W-1:0] sel;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    sel    = '0;
    // Scan from ptr upward, wrapping modulo NUM_REQ; first set bit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      sel = PTR_W'(pos);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        winner     = sel;
      end
    end
  end

endmodule

// File: rtl/iq_frame_controller.sv
// Frame sequencer and control-word arbiter for the IQ compression datapath.
// Counts accepted samples into FRAME_LEN-sample frames, pulses frameStart on each index-0
// sample, and once per frame grants one control-word requester round-robin, holding its word
// on controlData for the whole frame. All outputs registered, one cycle after the sample.
// clk : system clock
// rst : asynchronous active-low reset
// bus : slave side of iq_frame_controller_if (framing inputs, requests, registered outputs)
module iq_frame_controller
  import iq_frame_controller_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
  parameter int NUM_REQ    = NUM_CTRL_REQ,
  parameter int CTRL_WIDTH = SCALING_FACTOR_BITWIDTH
) (
  input logic                  clk,
  input logic                  rst,
  iq_frame_controller_if.slave bus
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  frame_state_t          state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  frame_start_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [CTRL_WIDTH-1:0] cdata_q;
  logic                  cvalid_q;
  logic [15:0]           fcount_q;
  logic                  busy_q;
  logic [PTR_W-1:0]      rr_ptr_q;

  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      winner;
  logic [CTRL_WIDTH-1:0] win_word;
  logic [PTR_W-1:0]      next_ptr;
  logic [IDX_W-1:0]      idx_inc;
  logic                  start_frame;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req    (bus.ctrlReq),
    .ptr    (rr_ptr_q),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_word = bus.ctrlWord[i*CTRL_WIDTH +: CTRL_WIDTH];
    end
    next_ptr = (winner == PTR_LAST) ? '0 : winner + PTR_ONE;
    idx_inc  = idx_q + IDX_ONE;
    // A new frame starts on the first sample out of IDLE, or on a wrapping sample in RUN
    // while enable is still high.
    start_frame = bus.inValid && bus.enable &&
                  ((state_q == IDLE) || ((state_q == RUN) && (idx_q == LAST_IDX)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
      ack_q         <= '0;
      cdata_q       <= '0;
      cvalid_q      <= 1'b0;
      fcount_q      <= '0;
      busy_q        <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      frame_start_q <= 1'b0;
      ack_q         <= '0;
      if (start_frame) begin
        state_q       <= RUN;
        busy_q        <= 1'b1;
        idx_q         <= '0;
        frame_start_q <= 1'b1;
        fcount_q      <= fcount_q + 16'd1;
        ack_q         <= grant;
        if (|bus.ctrlReq) begin
          cdata_q  <= win_word;
          cvalid_q <= 1'b1;
          rr_ptr_q <= next_ptr;
        end else begin
          cdata_q  <= '0;
          cvalid_q <= 1'b0;
        end
      end else if (bus.inValid) begin
        case (state_q)
          RUN: begin
            if (idx_q == LAST_IDX) begin
              // Wrapping sample with enable low: abandon it, no new frame.
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              cdata_q  <= '0;
              cvalid_q <= 1'b0;
            end else begin
              idx_q <= idx_inc;
              if (!bus.enable) begin
                if (idx_inc == LAST_IDX) begin
                  // Stop request landed on the final sample: frame already complete.
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  cdata_q  <= '0;
                  cvalid_q <= 1'b0;
                end else begin
                  state_q <= DRAIN;
                end
              end
            end
          end
          DRAIN: begin
            idx_q <= idx_inc;
            if (idx_inc == LAST_IDX) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              cdata_q  <= '0;
              cvalid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.frameStart   = frame_start_q;
  assign bus.ctrlAck      = ack_q;
  assign bus.sampleIdx    = idx_q;
  assign bus.controlData  = cdata_q;
  assign bus.controlValid = cvalid_q;
  assign bus.frameCount   = fcount_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_iq_frame_controller.sv
// Self-checking bench for iq_frame_controller (FRAME_LEN=16, NUM_REQ=4, 8-bit control words).
// Table rows drive inputs for a number of cycles, then compare every output against
// hand-computed values; reset-mid-frame and gapped-input runs are written out by hand.
module tb_iq_frame_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  iq_frame_controller_if bus_if ();

  iq_frame_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic        en;
    logic        vld;
    logic [3:0]  req;
    int          ncyc;
    logic        fs;
    logic [3:0]  ack;
    logic [3:0]  idx;
    logic        chk_idx;
    logic        cv;
    logic [7:0]  cd;
    logic [15:0] fc;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic v;
  logic [3:0] exp_idx;
  int   last_fs;
  int   n_pulses;

  function automatic vec_t mk(logic en, logic vld, logic [3:0] req, int ncyc, logic fs,
                              logic [3:0] ack, logic [3:0] idx, logic chk_idx, logic cv,
                              logic [7:0] cd, logic [15:0] fc, logic busy);
    vec_t r;
    r.en = en; r.vld = vld; r.req = req; r.ncyc = ncyc; r.fs = fs; r.ack = ack;
    r.idx = idx; r.chk_idx = chk_idx; r.cv = cv; r.cd = cd; r.fc = fc; r.busy = busy;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic fs, logic [3:0] ack, logic [3:0] idx, logic ci,
                         logic cv, logic [7:0] cd, logic [15:0] fc, logic busy);
    chk({tag, " frameStart"}, 32'(bus_if.frameStart), 32'(fs));
    chk({tag, " ctrlAck"}, 32'(bus_if.ctrlAck), 32'(ack));
    if (ci) chk({tag, " sampleIdx"}, 32'(bus_if.sampleIdx), 32'(idx));
    chk({tag, " controlValid"}, 32'(bus_if.controlValid), 32'(cv));
    chk({tag, " controlData"}, 32'(bus_if.controlData), 32'(cd));
    chk({tag, " frameCount"}, 32'(bus_if.frameCount), 32'(fc));
    chk({tag, " busy"}, 32'(bus_if.busy), 32'(busy));
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus_if.enable   = 1'b0;
    bus_if.inValid  = 1'b0;
    bus_if.ctrlReq  = '0;
    bus_if.ctrlWord = {8'h0D, 8'h0C, 8'h0B, 8'h0A};

    //   en vld req   n  fs ack idx ci cv cd     fc busy
    // basic framing, no requests
    vecs.push_back(mk(1, 1, 4'h0,  1, 1, 4'h0,  0, 1, 0, 8'h00,  1, 1));
    vecs.push_back(mk(1, 1, 4'h0,  1, 0, 4'h0,  1, 1, 0, 8'h00,  1, 1));
    vecs.push_back(mk(1, 1, 4'h0, 14, 0, 4'h0, 15, 1, 0, 8'h00,  1, 1));
    vecs.push_back(mk(1, 1, 4'h0,  1, 1, 4'h0,  0, 1, 0, 8'h00,  2, 1));
    vecs.push_back(mk(1, 1, 4'h0, 15, 0, 4'h0, 15, 1, 0, 8'h00,  2, 1));
    vecs.push_back(mk(1, 1, 4'h0,  1, 1, 4'h0,  0, 1, 0, 8'h00,  3, 1));
    // round robin, all requesters held
    vecs.push_back(mk(1, 1, 4'hF, 15, 0, 4'h0, 15, 1, 0, 8'h00,  3, 1));
    vecs.push_back(mk(1, 1, 4'hF,  1, 1, 4'h1,  0, 1, 1, 8'h0A,  4, 1));
    vecs.push_back(mk(1, 1, 4'hF,  1, 0, 4'h0,  1, 1, 1, 8'h0A,  4, 1));
    vecs.push_back(mk(1, 1, 4'hF, 14, 0, 4'h0, 15, 1, 1, 8'h0A,  4, 1));
    vecs.push_back(mk(1, 1, 4'hF,  1, 1, 4'h2,  0, 1, 1, 8'h0B,  5, 1));
    vecs.push_back(mk(1, 1, 4'hF, 15, 0, 4'h0, 15, 1, 1, 8'h0B,  5, 1));
    vecs.push_back(mk(1, 1, 4'hF,  1, 1, 4'h4,  0, 1, 1, 8'h0C,  6, 1));
    vecs.push_back(mk(1, 1, 4'hF, 15, 0, 4'h0, 15, 1, 1, 8'h0C,  6, 1));
    vecs.push_back(mk(1, 1, 4'hF,  1, 1, 4'h8,  0, 1, 1, 8'h0D,  7, 1));
    vecs.push_back(mk(1, 1, 4'hF, 15, 0, 4'h0, 15, 1, 1, 8'h0D,  7, 1));
    vecs.push_back(mk(1, 1, 4'hF,  1, 1, 4'h1,  0, 1, 1, 8'h0A,  8, 1));
    // requests withdrawn before the boundary: no grant, pointer stays at 1
    vecs.push_back(mk(1, 1, 4'h0, 15, 0, 4'h0, 15, 1, 1, 8'h0A,  8, 1));
    vecs.push_back(mk(1, 1, 4'h0,  1, 1, 4'h0,  0, 1, 0, 8'h00,  9, 1));
    // only requester 0 with pointer at 1: search wraps around to 0
    vecs.push_back(mk(1, 1, 4'h1, 15, 0, 4'h0, 15, 1, 0, 8'h00,  9, 1));
    vecs.push_back(mk(1, 1, 4'h1,  1, 1, 4'h1,  0, 1, 1, 8'h0A, 10, 1));
    // invalid cycles hold everything
    vecs.push_back(mk(1, 0, 4'h0,  2, 0, 4'h0,  0, 1, 1, 8'h0A, 10, 1));
    // drain: enable low from sample 5, frame completes at 15
    vecs.push_back(mk(1, 1, 4'h0,  4, 0, 4'h0,  4, 1, 1, 8'h0A, 10, 1));
    vecs.push_back(mk(0, 1, 4'h0,  1, 0, 4'h0,  5, 1, 1, 8'h0A, 10, 1));
    vecs.push_back(mk(0, 1, 4'h0,  9, 0, 4'h0, 14, 1, 1, 8'h0A, 10, 1));
    vecs.push_back(mk(0, 1, 4'h0,  1, 0, 4'h0, 15, 1, 0, 8'h00, 10, 0));
    vecs.push_back(mk(0, 1, 4'h0,  3, 0, 4'h0, 15, 1, 0, 8'h00, 10, 0));
    // boundary stop: enable drops on the wrapping sample
    vecs.push_back(mk(1, 1, 4'h2,  1, 1, 4'h2,  0, 1, 1, 8'h0B, 11, 1));
    vecs.push_back(mk(1, 1, 4'h0, 15, 0, 4'h0, 15, 1, 1, 8'h0B, 11, 1));
    vecs.push_back(mk(0, 1, 4'h0,  1, 0, 4'h0,  0, 0, 0, 8'h00, 11, 0));
    vecs.push_back(mk(1, 0, 4'h0,  2, 0, 4'h0,  0, 0, 0, 8'h00, 11, 0));

    // reset state
    #12;
    chk_all("reset", 0, 4'h0, 4'h0, 1, 0, 8'h00, 16'd0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[r]) begin
      bus_if.enable  = vecs[r].en;
      bus_if.inValid = vecs[r].vld;
      bus_if.ctrlReq = vecs[r].req;
      cycles(vecs[r].ncyc);
      chk_all($sformatf("row%0d", r), vecs[r].fs, vecs[r].ack, vecs[r].idx, vecs[r].chk_idx,
              vecs[r].cv, vecs[r].cd, vecs[r].fc, vecs[r].busy);
    end

    // reset mid-frame with a grant active (pointer is 2 here)
    bus_if.enable  = 1'b1;
    bus_if.inValid = 1'b1;
    bus_if.ctrlReq = 4'hF;
    cycles(1);
    chk_all("rst_pre0", 1, 4'h4, 4'h0, 1, 1, 8'h0C, 16'd12, 1);
    cycles(7);
    chk_all("rst_pre7", 0, 4'h0, 4'h7, 1, 1, 8'h0C, 16'd12, 1);
    rst = 1'b0;
    #1;
    chk_all("rst_mid", 0, 4'h0, 4'h0, 1, 0, 8'h00, 16'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    cycles(1);
    chk_all("rst_restart", 1, 4'h1, 4'h0, 1, 1, 8'h0A, 16'd1, 1);

    // gapped input: one valid sample every third cycle, frames 48 cycles apart
    bus_if.ctrlReq = '0;
    exp_idx  = 4'd0;
    last_fs  = 0;
    n_pulses = 0;
    for (int c = 1; c <= 96; c++) begin
      v = ((c % 3) == 0);
      bus_if.inValid = v;
      cycles(1);
      if (v) exp_idx = exp_idx + 4'd1;
      chk($sformatf("gap%0d frameStart", c), 32'(bus_if.frameStart),
          32'(v && (exp_idx == 4'd0)));
      chk($sformatf("gap%0d sampleIdx", c), 32'(bus_if.sampleIdx), 32'(exp_idx));
      if (bus_if.frameStart) begin
        chk($sformatf("gap%0d spacing", c), 32'(c - last_fs), 32'd48);
        last_fs = c;
        n_pulses++;
      end
    end
    chk("gap pulses", 32'(n_pulses), 32'd2);
    chk("gap frameCount", 32'(bus_if.frameCount), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
